// File: rtl/retospect_neuron_cell.sv
// retospect_neuron_cell: leaky integrate-and-fire neuron with signed dendrite
// weights, programmable threshold and refractory period, saturating membrane
// potential, and a daisy-chained shift-register configuration.
module retospect_neuron_cell #(
  parameter int N_DEND   = 4,
  parameter int W_BITS   = 4,
  parameter int P_BITS   = 6,
  parameter int R_BITS   = 3,
  parameter int SEL_BITS = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     reset_nn,
  input  logic                     config_en,
  input  logic                     bs_in,
  output logic                     bs_out,
  input  logic [2**SEL_BITS-1:0]   clockbus,
  input  logic [N_DEND-1:0]        dendrite,
  output logic                     axon
);

  localparam int L      = N_DEND*W_BITS + P_BITS + R_BITS + SEL_BITS;
  localparam int SUM_W  = W_BITS + $clog2(N_DEND) + 1;
  localparam int NXT_W  = ((P_BITS + 1 > SUM_W) ? P_BITS + 1 : SUM_W) + 1;
  localparam int V_MAX  = 2**P_BITS - 1;
  localparam logic signed [NXT_W-1:0] SAT_HI = NXT_W'(V_MAX);

  typedef enum logic {INTEG = 1'b0, REFR = 1'b1} state_t;

  // Configuration chain, w[0] in the MSBs, decay_sel in the LSBs.
  logic [L-1:0]        r_chain;
  state_t              r_state;
  logic [P_BITS-1:0]   r_v;
  logic [R_BITS-1:0]   r_cnt;
  logic                r_axon;

  state_t              w_state_nxt;
  logic [P_BITS-1:0]   w_v_nxt;
  logic [R_BITS-1:0]   w_cnt_nxt;
  logic                w_axon_nxt;

  logic signed [W_BITS-1:0] w_wt [N_DEND];
  logic [P_BITS-1:0]   w_thr;
  logic [R_BITS-1:0]   w_refr;
  logic [SEL_BITS-1:0] w_dsel;
  logic signed [SUM_W-1:0] w_sum;
  logic                w_leak;
  logic [P_BITS-1:0]   w_vl;
  logic signed [NXT_W-1:0] w_nxt_raw;
  logic [P_BITS-1:0]   w_nxt;
  logic                w_fire;

  // Clamp a signed candidate potential into [0, 2**P_BITS-1].
  function automatic logic [P_BITS-1:0] sat_pot(input logic signed [NXT_W-1:0] x);
    if (x[NXT_W-1])
      return '0;
    else if (x > SAT_HI)
      return P_BITS'(V_MAX);
    else
      return x[P_BITS-1:0];
  endfunction

  genvar g;
  for (g = 0; g < N_DEND; g++) begin : g_wt
    assign w_wt[g] = r_chain[L-1-g*W_BITS -: W_BITS];
  end

  assign w_thr  = r_chain[R_BITS+SEL_BITS +: P_BITS];
  assign w_refr = r_chain[SEL_BITS +: R_BITS];
  assign w_dsel = r_chain[SEL_BITS-1:0];
  assign bs_out = r_chain[0];
  assign axon   = r_axon;

  // Signed sum of the weights of all active dendrites; wide enough never to wrap.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < N_DEND; i++) begin
      if (dendrite[i])
        w_sum = w_sum + {{(SUM_W-W_BITS){w_wt[i][W_BITS-1]}}, w_wt[i]};
    end
  end

  // Leak halves the potential before the synaptic sum is added.
  assign w_leak    = clockbus[w_dsel];
  assign w_vl      = w_leak ? (r_v >> 1) : r_v;
  assign w_nxt_raw = {{(NXT_W-P_BITS){1'b0}}, w_vl} + {{(NXT_W-SUM_W){w_sum[SUM_W-1]}}, w_sum};
  assign w_nxt     = sat_pot(w_nxt_raw);
  assign w_fire    = (w_nxt >= w_thr);

  // Shift the configuration chain one bit right while config_en is high.
  always_ff @(posedge clk) begin
    if (reset)
      r_chain <= '0;
    else if (!reset_nn && config_en)
      r_chain <= {bs_in, r_chain[L-1:1]};
  end

  // Neuron state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= INTEG;
      r_v     <= '0;
      r_cnt   <= '0;
      r_axon  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_v     <= w_v_nxt;
      r_cnt   <= w_cnt_nxt;
      r_axon  <= w_axon_nxt;
    end
  end

  // Next state: soft reset, configuration hold, integrate/fire, refractory countdown.
  always_comb begin
    w_state_nxt = r_state;
    w_v_nxt     = r_v;
    w_cnt_nxt   = r_cnt;
    w_axon_nxt  = 1'b0;
    if (reset_nn) begin
      w_state_nxt = INTEG;
      w_v_nxt     = P_BITS'(1);
      w_cnt_nxt   = '0;
    end else if (!config_en) begin
      case (r_state)
        INTEG: begin
          if (w_fire) begin
            w_axon_nxt = 1'b1;
            w_v_nxt    = '0;
            if (w_refr != '0) begin
              w_state_nxt = REFR;
              w_cnt_nxt   = w_refr;
            end
          end else begin
            w_v_nxt = w_nxt;
          end
        end
        REFR: begin
          w_v_nxt = '0;
          if (r_cnt <= R_BITS'(1)) begin
            w_state_nxt = INTEG;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
        default: begin
          w_state_nxt = INTEG;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_retospect_neuron_cell.sv
// Directed testbench for retospect_neuron_cell with default parameters.
module tb_retospect_neuron_cell;

  logic       clk = 1'b0;
  logic       reset, reset_nn, config_en, bs_in;
  logic       bs_out, axon;
  logic [7:0] clockbus;
  logic [3:0] dendrite;

  int n_tests = 0;
  int n_fail  = 0;

  retospect_neuron_cell dut (
    .clk(clk), .reset(reset), .reset_nn(reset_nn), .config_en(config_en),
    .bs_in(bs_in), .bs_out(bs_out), .clockbus(clockbus),
    .dendrite(dendrite), .axon(axon)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_cfg(input logic [3:0] a0, input logic [3:0] a1,
                          input logic [3:0] a2, input logic [3:0] a3,
                          input logic [5:0] th, input logic [2:0] rf,
                          input logic [2:0] ds);
    logic [27:0] c;
    c = {a0, a1, a2, a3, th, rf, ds};
    for (int k = 0; k < 28; k++) begin
      config_en = 1'b1;
      bs_in     = c[k];
      tick();
    end
    config_en = 1'b0;
    bs_in     = 1'b0;
  endtask

  task automatic soft_reset;
    reset_nn = 1'b1;
    tick();
    reset_nn = 1'b0;
  endtask

  logic [27:0] pat;
  logic [27:0] c5;
  logic [5:0]  leak_exp [7];

  initial begin
    reset = 1'b1; reset_nn = 1'b0; config_en = 1'b0; bs_in = 1'b0;
    clockbus = '0; dendrite = '0;
    tick(); tick();
    reset = 1'b0;
    check_val("rst_axon", axon, 0);
    check_val("rst_bs_out", bs_out, 0);
    check_val("rst_v", dut.r_v, 0);

    // 1. chain passthrough with a pause in the middle
    pat = 28'hA5C31E7;
    for (int k = 1; k <= 56; k++) begin
      if (k == 40) begin
        config_en = 1'b0; bs_in = 1'b1;
        repeat (3) tick();
      end
      if (k >= 29) check_val("chain_pass", bs_out, pat[k-29]);
      config_en = 1'b1;
      bs_in = (k <= 28) ? pat[k-1] : 1'b0;
      tick();
    end
    config_en = 1'b0; bs_in = 1'b0;

    // 2. integration to threshold, pulses every 3 cycles
    load_cfg(4'd3, 4'd0, 4'd0, 4'd0, 6'd9, 3'd0, 3'd0);
    soft_reset();
    check_val("int_v1", dut.r_v, 1);
    dendrite = 4'b0001;
    tick(); check_val("int_v4", dut.r_v, 4); check_val("int_ax0", axon, 0);
    tick(); check_val("int_v7", dut.r_v, 7); check_val("int_ax0", axon, 0);
    tick(); check_val("int_fire_v", dut.r_v, 0); check_val("int_fire_ax", axon, 1);
    tick(); check_val("int_v3", dut.r_v, 3); check_val("int_pulse_w", axon, 0);
    tick(); check_val("int_v6", dut.r_v, 6);
    tick(); check_val("int_fire2_ax", axon, 1); check_val("int_fire2_v", dut.r_v, 0);
    dendrite = '0;

    // 3. inhibition, clamp at 0 and at the top
    load_cfg(4'd4, 4'h8, 4'd0, 4'd0, 6'd63, 3'd0, 3'd0);
    soft_reset();
    dendrite = 4'b0001; tick(); check_val("inh_v5", dut.r_v, 5);
    dendrite = 4'b0010; tick(); check_val("inh_clamp0", dut.r_v, 0); check_val("inh_ax", axon, 0);
    dendrite = '0;
    load_cfg(4'd7, 4'h8, 4'd0, 4'd0, 6'd63, 3'd0, 3'd0);
    dendrite = 4'b0011; tick(); check_val("mix_sum0", dut.r_v, 0);
    dendrite = '0;
    load_cfg(4'd7, 4'd7, 4'd7, 4'd7, 6'd63, 3'd0, 3'd0);
    check_val("cfg_hold_v", dut.r_v, 0);
    dendrite = 4'b1111;
    tick(); check_val("sat_v28", dut.r_v, 28);
    tick(); check_val("sat_v56", dut.r_v, 56); check_val("sat_ax0", axon, 0);
    tick(); check_val("sat_fire", axon, 1); check_val("sat_v0", dut.r_v, 0);
    dendrite = '0;

    // 4. refractory period
    load_cfg(4'd7, 4'd0, 4'd0, 4'd0, 6'd7, 3'd3, 3'd0);
    soft_reset();
    dendrite = 4'b0001;
    tick(); check_val("ref_fire1", axon, 1);
    for (int k = 0; k < 3; k++) begin
      tick(); check_val("ref_quiet_ax", axon, 0); check_val("ref_quiet_v", dut.r_v, 0);
    end
    tick(); check_val("ref_fire2", axon, 1);
    reset_nn = 1'b1; tick(); reset_nn = 1'b0;
    check_val("ref_abort_v", dut.r_v, 1);
    check_val("ref_abort_st", dut.r_state, 0);
    check_val("ref_abort_ax", axon, 0);
    tick(); check_val("ref_abort_fire", axon, 1);
    dendrite = '0;
    repeat (3) tick();

    // 5. leak
    load_cfg(4'd3, 4'd7, 4'd7, 4'd6, 6'd63, 3'd0, 3'd1);
    soft_reset();
    dendrite = 4'b1111; tick(); check_val("lk_v24", dut.r_v, 24);
    dendrite = 4'b1011; tick(); check_val("lk_v40", dut.r_v, 40);
    dendrite = '0;
    clockbus = 8'b0000_0001; tick(); check_val("lk_unsel", dut.r_v, 40);
    clockbus = 8'b0000_0010;
    leak_exp = '{6'd20, 6'd10, 6'd5, 6'd2, 6'd1, 6'd0, 6'd0};
    for (int k = 0; k < 7; k++) begin
      tick(); check_val("lk_seq", dut.r_v, leak_exp[k]);
    end
    clockbus = '0;
    dendrite = 4'b0010; tick(); check_val("lk_v7", dut.r_v, 7);
    dendrite = 4'b0001; tick(); check_val("lk_v10", dut.r_v, 10);
    clockbus = 8'b0000_0010; tick(); check_val("lk_then_add", dut.r_v, 8);
    clockbus = '0; dendrite = '0;

    // 6. priority
    c5 = {4'd3, 4'd7, 4'd7, 4'd6, 6'd63, 3'd0, 3'd1};
    reset_nn = 1'b1; config_en = 1'b1; bs_in = 1'b1; dendrite = 4'b1111;
    tick();
    check_val("pri_nn_chain", dut.r_chain, c5);
    check_val("pri_nn_v", dut.r_v, 1);
    reset_nn = 1'b0; bs_in = 1'b0;
    tick();
    check_val("pri_cfg_v", dut.r_v, 1);
    check_val("pri_cfg_ax", axon, 0);
    check_val("pri_cfg_chain", dut.r_chain, c5 >> 1);
    tick();
    check_val("pri_cfg_v2", dut.r_v, 1);
    check_val("pri_cfg_ax2", axon, 0);
    reset = 1'b1; bs_in = 1'b1;
    tick();
    check_val("pri_rst_chain", dut.r_chain, 0);
    check_val("pri_rst_bs", bs_out, 0);
    check_val("pri_rst_v", dut.r_v, 0);
    reset = 1'b0; config_en = 1'b0; bs_in = 1'b0; dendrite = '0;

    // reset while refractory clears everything
    load_cfg(4'd7, 4'd0, 4'd0, 4'd0, 6'd7, 3'd3, 3'd0);
    soft_reset();
    dendrite = 4'b0001; tick();
    check_val("rr_state_refr", dut.r_state, 1);
    reset = 1'b1; tick(); reset = 1'b0; dendrite = '0;
    check_val("rr_state", dut.r_state, 0);
    check_val("rr_ax", axon, 0);
    check_val("rr_chain", dut.r_chain, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
